lz77_enc_sequencer: RTL

Session controller for the LZ77 encoder datapath. It fetches one image of IMG_LEN bytes from a byte-wide image memory and drives the encoder's reset and chardata stream with the required one-byte-per-cycle timing. It captures each emitted (offset, match_len, char_nxt) token into a small FIFO, presents the tokens downstream with valid/ready, and reports session completion and overflow.

---
 rtl/lz77_enc_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/lz77_enc_sequencer.sv
// Session controller: streams one IMG_LEN-byte image into the LZ77 encoder and buffers its tokens for a valid/ready consumer.
// Optional feature macro LZ77_SEQ_TOKCNT_EN implements the tok_count counter; otherwise tok_count is tied to zero.
module lz77_enc_sequencer #(
    parameter int IMG_LEN    = 2049,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        mem_rd,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        enc_reset,
    output logic [7:0]  enc_chardata,
    input  logic        enc_valid,
    input  logic        enc_finish,
    input  logic [3:0]  enc_offset,
    input  logic [2:0]  enc_match_len,
    input  logic [7:0]  enc_char_nxt,
    output logic        tok_valid,
    input  logic        tok_ready,
    output logic [14:0] tok_data,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [11:0] tok_count
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = PW - 1;
    localparam logic [11:0] LAST_N = 12'(IMG_LEN - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST    = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]    state;
    logic [11:0]   n;
    logic [12:0]   n_nxt;
    logic [PW-1:0] wr_ptr, rd_ptr, occ;
    logic [14:0]   fifo_mem [FIFO_DEPTH];
    logic          push, pop, full, wr_en, sess_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            n     <= '0;
        end else begin
            case (state)
                S_IDLE:   if (start) state <= S_RST;
                S_RST: begin
                    state <= S_STREAM;
                    n     <= '0;
                end
                S_STREAM: if (n == LAST_N) state <= S_DRAIN;
                          else n <= n + 12'd1;
                S_DRAIN:  if (enc_finish) state <= S_FLUSH;
                S_FLUSH:  if (!tok_valid) state <= S_DONE;
                S_DONE:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Read address runs one byte ahead so memory latency hides behind the stream.
    assign n_nxt = {1'b0, n} + 13'd1;

    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = '0;
        if (state == S_RST) begin
            mem_rd = 1'b1;
        end else if (state == S_STREAM && n_nxt < 13'(IMG_LEN)) begin
            mem_rd   = 1'b1;
            mem_addr = n_nxt[11:0];
        end
    end

    assign enc_reset    = reset | (state == S_RST);
    assign enc_chardata = (state == S_STREAM) ? mem_rdata : 8'h00;
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);

    assign sess_clr  = (state == S_IDLE) && start;
    assign occ       = wr_ptr - rd_ptr;
    assign full      = (occ == PW'(FIFO_DEPTH));
    assign tok_valid = (occ != '0);
    assign pop       = tok_valid & tok_ready;
    assign push      = enc_valid;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    assign wr_en     = push && (!full || pop) && !sess_clr;
    assign tok_data  = tok_valid ? fifo_mem[rd_ptr[IW-1:0]] : 15'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (sess_clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr[IW-1:0]] <= {enc_offset, enc_match_len, enc_char_nxt};
    end

`ifdef LZ77_SEQ_TOKCNT_EN
    logic [11:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          cnt_q <= '0;
        else if (sess_clr)                  cnt_q <= '0;
        else if (pop && cnt_q != 12'hFFF)   cnt_q <= cnt_q + 12'd1;
    end

    assign tok_count = cnt_q;
`else
    assign tok_count = 12'd0;
`endif

endmodule
